// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation converter.
// Imported by the handshake interface, the step datapath and the FSM top.
package sar_pkg;

  localparam int N_DEF      = 8;
  localparam int SETTLE_DEF = 1;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    TRIAL,
    DONE_WAIT
  } state_e;

endpackage

// File: rtl/sar_converter_if.sv
// Consumer-side start/end-of-conversion handshake and sample bus.
// master = consumer (drives soc), slave = converter.
interface sar_converter_if
  import sar_pkg::*;
#(
  parameter int N = N_DEF
);

  logic         soc;
  logic         eoc;
  logic [N-1:0] x;

  modport master (
    output soc,
    input  eoc,
    input  x
  );

  modport slave (
    input  soc,
    output eoc,
    output x
  );

endinterface

// File: rtl/sar_step.sv
// SAR datapath: result register, one-hot trial mask and DAC code.
// load starts a conversion, step applies one comparator decision.
module sar_step #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         cmp,
  output logic [N-1:0] result,
  output logic [N-1:0] res_nxt,
  output logic [N-1:0] dac,
  output logic         last
);

  localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0] res_q, res_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] dac_q, dac_d;

  always_comb begin
    res_d  = res_q;
    mask_d = mask_q;
    dac_d  = dac_q;
    if (load) begin
      res_d  = '0;
      mask_d = MSB;
      dac_d  = MSB;
    end else if (step) begin
      // cmp is only looked at here, so it may be X between decisions
      res_d  = cmp ? (res_q | mask_q) : res_q;
      mask_d = mask_q >> 1;
      dac_d  = res_d | mask_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_q  <= '0;
      mask_q <= '0;
      dac_q  <= '0;
    end else begin
      res_q  <= res_d;
      mask_q <= mask_d;
      dac_q  <= dac_d;
    end
  end

  assign result  = res_q;
  assign res_nxt = res_d;
  assign dac     = dac_q;
  assign last    = mask_q[0];

endmodule

// File: rtl/sar_converter.sv
// Successive-approximation A/D controller: FSM, settle timing and
// soc/eoc handshake around the sar_step datapath.
module sar_converter
  import sar_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic         clock,
  input  logic         reset,
  sar_converter_if.slave conv,
  output logic [N-1:0] dac,
  input  logic         cmp
);

  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eoc_q, eoc_d;
  logic [N-1:0]     x_q, x_d;

  logic         load;
  logic         step;
  logic         last;
  logic [N-1:0] result;
  logic [N-1:0] res_nxt;

  sar_step #(
    .N (N)
  ) u_step (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .cmp     (cmp),
    .result  (result),
    .res_nxt (res_nxt),
    .dac     (dac),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eoc_d   = eoc_q;
    x_d     = x_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (conv.soc) begin
          load    = 1'b1;
          eoc_d   = 1'b0;
          cnt_d   = '0;
          state_d = TRIAL;
        end
      end
      TRIAL: begin
        if (cnt_q == SET_LAST) begin
          step  = 1'b1;
          cnt_d = '0;
          if (last) begin
            // result must not reach x until the consumer drops soc
            if (!conv.soc) begin
              x_d     = res_nxt;
              eoc_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DONE_WAIT;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE_WAIT: begin
        if (!conv.soc) begin
          x_d     = result;
          eoc_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      eoc_q   <= 1'b1;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eoc_q   <= eoc_d;
      x_q     <= x_d;
    end
  end

  assign conv.eoc = eoc_q;
  assign conv.x   = x_q;

endmodule

// File: doc/sar_converter.md
# sar_converter

- Upstream stage of the sample-smoothing unit: a successive-approximation A/D converter controller.
- Serves the `soc`/`eoc` start/end-of-conversion handshake on its consumer side and delivers the 8-bit sample `x`.
- Drives an external DAC and reads an external comparator on its analog side.
- Replaces the behavioural converter model used on benches, so the smoothing unit can be checked in closed loop against an analog stub.

## Interface
Parameters:
- `N`, 8: conversion width in bits.
- `SETTLE`, 1: extra hold cycles per trial bit before the comparator is sampled (0..15).

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `soc`  in  1  start of conversion, from the consumer.
- `eoc`  out  1  end of conversion; 1 means idle and `x` is valid.
- `x`  out  N  last completed conversion result.
- `dac`  out  N  trial code driven to the external DAC.
- `cmp`  in  1  comparator output; 1 iff analog input >= DAC voltage for the current `dac`.

## Operation
- States: IDLE, TRIAL, DONE_WAIT.
- IDLE: `eoc`=1. `x` and `dac` hold their values.
  - `soc`=1 sampled: clear the result register and set the mask to bit N-1.
  - In the same edge: `dac` <= 1<<(N-1), `eoc` <= 0, go to TRIAL.
- TRIAL: each bit occupies SETTLE+1 cycles, timed by a settle counter.
  - At the last edge of the bit period, sample `cmp`: 1 keeps the mask bit in the result, 0 clears it.
  - The mask shifts right and `dac` <= result | next mask.
  - After the LSB decision, `dac` <= final result.
  - If `soc`=0 at that edge: `x` <= result, `eoc` <= 1, go to IDLE.
  - Otherwise go to DONE_WAIT.
- DONE_WAIT: hold. On the first edge with `soc`=0: `x` <= result, `eoc` <= 1, go to IDLE.
- `soc` is ignored while not in IDLE, apart from the DONE_WAIT release condition.
- `x` changes only on the edge where `eoc` rises. During a conversion `x` holds the previous result.
- Arithmetic is unsigned N-bit. No carries: the result is built only by bit set/clear.

## Timing
- Reset values: `eoc`=1, `x`=0, `dac`=0, state IDLE, counters 0.
- Reset asserted mid-conversion aborts immediately to these values. No partial result reaches `x`.
- `soc` already high at reset release: conversion starts on the first edge.
- `eoc` falls on the edge after `soc` is first sampled high (edge k).
- The decision for bit N-1-j is taken at edge k+(j+1)(SETTLE+1).
- The last decision is at edge k+N(SETTLE+1), which is 16 edges for the defaults.
- `eoc` rises at that edge, or at the first later edge where `soc`=0.
- Handshake required of the consumer:
  - raise `soc` only while `eoc`=1;
  - drop `soc` after seeing `eoc`=0.
- Guarantee: `x` is stable from `eoc` rise until the next `eoc` rise.
- `cmp` is sampled only at decision edges. It may be X at all other times without effect.

## Structure
- Shared package `sar_pkg` holds:
  - the state enum (IDLE, TRIAL, DONE_WAIT);
  - the default constants for `N` and `SETTLE`;
  - the settle-counter width.
- One natural sub-module, `sar_step`: the result register, the one-hot mask shifter and the `dac` composition.
  - Inputs: load, step, `cmp`.
  - Output: result, `dac`, last-bit flag.
- The FSM, settle counter and handshake stay in `sar_converter`.

## Test plan
The bench models the analog side as `cmp` = (vin >= `dac`).
- Reset, then hold → `eoc`=1, `x`=0, `dac`=0. `soc`=1 during reset causes no activity.
- vin=200, defaults, `soc` pulse of 3 cycles:
  - trial codes 128, 192, 224, 208, 200, 204, 202, 201;
  - `eoc` low for exactly 16 edges;
  - `x`=200.
- vin=0 → `x`=0. vin=255 → `x`=255. Both complete in 16 edges.
- `soc` held high 25 cycles with vin=77 → DONE_WAIT is entered. `eoc` rises on the first edge after `soc` falls, with `x`=77.
- vin=100 then reset at edge 7 of the conversion:
  - `eoc`=1, `x`=0 asynchronously;
  - the next conversion yields 100.
- Closed loop with the smoothing unit, 128 samples, `SETTLE`=3 → every sample delivered in 32 edges. Each `x` matches vin while `eoc`=1.
